fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Round-robin, burst-locking arbiter that shares the single framebuffer write port between the pixel producers of the graphics pipeline: background clear, rasterizer pixel stream and sprite drawer. Sits between those producers and the back-buffer BRAM write port, under the frame-level drawing manager. Each requester owns the port for a whole burst, so a clear pass or a triangle's pixel stream is never interleaved with another source. Output is registered for BRAM timing.

## Interface

- `NUM_REQ`, default 3: number of requesters. Index 0 is background, 1 is rasterizer, 2 is sprite.
- `BUFFER_WIDTH`, default 160: framebuffer width in pixels.
- `BUFFER_HEIGHT`, default 120: framebuffer height in pixels.
- `DATA_WIDTH`, default 12: pixel width, RGB444.
- `ADDR_WIDTH`, default `$clog2(BUFFER_WIDTH*BUFFER_HEIGHT)`: write address width.
- `clk`, input, 1: single clock.
- `rst`, input, 1: **synchronous, active-high** reset (already decided; one clock domain).
- `req_valid`, input, NUM_REQ: per-requester beat valid.
- `req_ready`, output, NUM_REQ: per-requester beat accepted.
- `req_last`, input, NUM_REQ: beat is the final beat of the burst.
- `req_addr`, input, NUM_REQ*ADDR_WIDTH: packed addresses. Requester i occupies bits `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_data`, input, NUM_REQ*DATA_WIDTH: packed pixel data, same packing as `req_addr`.
- `write_en`, output, 1: framebuffer write strobe.
- `write_addr`, output, ADDR_WIDTH: framebuffer address.
- `write_data`, output, DATA_WIDTH: framebuffer data.
- `owner`, output, $clog2(NUM_REQ): index of the current owner. Valid only while `locked` is 1.
- `locked`, output, 1: a burst is in progress.
- `oob_count`, output, 16: count of dropped out-of-range beats (see Configuration).

## Operation

- States are ARBITRATE and LOCKED.
- **ARBITRATE**
  - All `req_ready` are 0.
  - If any `req_valid` is set, grant the first requester found at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Register `owner` to that index and go to LOCKED.
  - If no `req_valid` is set, stay in ARBITRATE.
- **LOCKED**
  - `req_ready[owner]` is 1; every other `req_ready` is 0. The ready is combinational from state and `owner`, and does not depend on `req_valid`.
  - A handshake occurs when `req_valid[owner]` and `req_ready[owner]` are both 1. Each handshake captures `req_addr` and `req_data` of the owner into the output register.
  - `req_valid[owner]` low inside a burst: the owner keeps the lock, no write is issued, and other requesters wait.
  - A handshake with `req_last[owner]=1` ends the burst:
    - next state is ARBITRATE;
    - `rr_ptr` becomes `(owner+1) mod NUM_REQ`.
- Non-owner `req_valid`, `req_last` and payload are ignored while LOCKED.
- `req_last` sampled outside a handshake has no effect.
- Requesters must hold valid and payload stable until ready (AXI-stream rules). The arbiter is never back-pressured downstream.
- Addresses are forwarded without arithmetic. Bounds checking is described under Configuration.

## Timing

- Reset values:
  - state ARBITRATE;
  - `rr_ptr` 0, `owner` 0, `locked` 0;
  - `req_ready` all 0;
  - `write_en` 0, `write_addr` 0, `write_data` 0;
  - `oob_count` 0.
- Reset asserted mid-burst: the lock is dropped on that edge with no further write. The pending output beat registered in the same cycle is discarded, so `write_en` is 0 on the following cycle.
- Arbitration latency:
  - a request seen in ARBITRATE in cycle N gives `req_ready` high in cycle N+1;
  - this yields one bubble cycle between consecutive bursts.
- Write latency: a handshake in cycle N gives `write_en`, `write_addr` and `write_data` in cycle N+1, for exactly one cycle per beat.
- Throughput: one beat per cycle within a burst.
- Single-beat burst (`req_last` on the first beat) gives 2 cycles per grant.
- Simultaneous requests: resolved by `rr_ptr` only, with no fixed priority. With all requesters continuously valid, the grant order cycles 0,1,2,0,…
- `locked` equals (state == LOCKED) and is registered.

## Configuration

- Macro: `FB_WRITE_ARBITER_BOUNDS_CHECK_EN`.
- **Defined:** a handshake whose address is ≥ BUFFER_WIDTH*BUFFER_HEIGHT still completes:
  - ready stays high;
  - `req_last` is honoured;
  - `write_en` stays 0 in the next cycle;
  - `oob_count` increments, saturating at 16'hFFFF.
- **Undefined:** every handshake is forwarded unchanged, and `oob_count` is tied to 0.

## Test plan

- Reset, then idle for 10 cycles: `write_en`, `req_ready` and `locked` all stay 0.
- Requester 1 sends a 4-beat burst at addr 10..13, data 12'h0A0:
  - `req_ready[1]` rises 1 cycle after valid;
  - `write_en` is high for 4 consecutive cycles with addr 10..13;
  - `locked` falls after the last beat.
- Requesters 0, 1 and 2 are held valid, each sending 2-beat bursts: the grant order is 0,1,2,0, with exactly one bubble cycle between bursts and no interleaved addresses.
- Owner drops valid for 3 cycles mid-burst while requester 2 is valid:
  - `owner` is unchanged;
  - `write_en` is 0 for those 3 cycles;
  - requester 2 is granted only after the owner's last beat.
- Assert `rst` during beat 2 of a 5-beat burst:
  - next cycle: `write_en`=0 and `locked`=0;
  - after reset, requester 0 is granted first (`rr_ptr`=0).
- With `FB_WRITE_ARBITER_BOUNDS_CHECK_EN` defined, send addr 19200 then addr 19199 (last):
  - the first beat produces no write;
  - the second beat is written;
  - `oob_count`=1.
  - Without the macro, both beats are written and `oob_count`=0.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Round-robin, burst-locking arbiter sharing one framebuffer write port among pixel producers.
// Optional out-of-range address dropping is enabled by defining FB_WRITE_ARBITER_BOUNDS_CHECK_EN.
module fb_write_arbiter #(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned BUFFER_WIDTH  = 160,
    parameter int unsigned BUFFER_HEIGHT = 120,
    parameter int unsigned DATA_WIDTH    = 12,
    parameter int unsigned ADDR_WIDTH    = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
    localparam int unsigned OwnerW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic                             write_en,
    output logic [ADDR_WIDTH-1:0]            write_addr,
    output logic [DATA_WIDTH-1:0]            write_data,
    output logic [OwnerW-1:0]                owner,
    output logic                             locked,
    output logic [15:0]                      oob_count
);

    typedef enum logic {StArbitrate, StLocked} state_e;

    state_e                  state;
    logic [OwnerW-1:0]       rr_ptr;
    logic [OwnerW-1:0]       grant_idx;
    logic                    grant_found;
    int unsigned             cand;
    logic [ADDR_WIDTH-1:0]   own_addr;
    logic [DATA_WIDTH-1:0]   own_data;
    logic                    own_valid;
    logic                    own_last;
    logic                    handshake;
    logic                    write_ok;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[OwnerW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = OwnerW'(cand);
            end
        end
    end

    always_comb begin
        own_addr  = '0;
        own_data  = '0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == OwnerW'(i)) begin
                own_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                own_valid = req_valid[i];
                own_last  = req_last[i];
                req_ready[i] = (state == StLocked);
            end
        end
    end

    assign handshake = (state == StLocked) && own_valid;

`ifdef FB_WRITE_ARBITER_BOUNDS_CHECK_EN
    localparam int unsigned NumPixels = BUFFER_WIDTH * BUFFER_HEIGHT;
    logic [15:0] oob_q;

    assign write_ok  = 32'(own_addr) < NumPixels;
    assign oob_count = oob_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_q <= '0;
        end else if (handshake && !write_ok && oob_q != 16'hFFFF) begin
            oob_q <= oob_q + 16'd1;
        end
    end
`else
    assign write_ok  = 1'b1;
    assign oob_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StArbitrate;
            rr_ptr     <= '0;
            owner      <= '0;
            locked     <= 1'b0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            write_en <= 1'b0;
            unique case (state)
                StArbitrate: begin
                    if (grant_found) begin
                        owner  <= grant_idx;
                        state  <= StLocked;
                        locked <= 1'b1;
                    end
                end
                StLocked: begin
                    if (handshake) begin
                        write_addr <= own_addr;
                        write_data <= own_data;
                        write_en   <= write_ok;
                        if (own_last) begin
                            state  <= StArbitrate;
                            locked <= 1'b0;
                            rr_ptr <= (owner == OwnerW'(NUM_REQ - 1)) ? '0
                                                                      : owner + OwnerW'(1);
                        end
                    end
                end
                default: state <= StArbitrate;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_fb_write_arbiter;

    localparam int NR = 3;
    localparam int AW = 15;
    localparam int DW = 12;
`ifdef FB_WRITE_ARBITER_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_last = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic            write_en;
    logic [AW-1:0]   write_addr;
    logic [DW-1:0]   write_data;
    logic [1:0]      owner;
    logic            locked;
    logic [15:0]     oob_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_last   (req_last),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .owner      (owner),
        .locked     (locked),
        .oob_count  (oob_count)
    );

    // Reference model: who holds the port, the rotation pointer, and the pending write.
    bit          m_busy = 1'b0;
    int          m_owner = 0;
    int          m_ptr = 0;
    int          m_oob = 0;
    bit          m_wen = 1'b0;
    int          m_waddr = 0;
    int          m_wdata = 0;
    bit [NR-1:0] hs_vec = '0;

    always @(posedge clk) begin
        hs_vec = '0;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_oob = 0; m_wen = 0;
        end else begin
            m_wen = 0;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    if (!m_busy && req_valid[(m_ptr + k) % NR]) begin
                        m_busy  = 1;
                        m_owner = (m_ptr + k) % NR;
                    end
                end
            end else if (req_valid[m_owner]) begin
                int a;
                hs_vec[m_owner] = 1'b1;
                a = int'(req_addr[m_owner*AW +: AW]);
                if (BoundsEn && a >= 160 * 120) begin
                    m_oob = (m_oob == 65535) ? 65535 : m_oob + 1;
                end else begin
                    m_wen   = 1;
                    m_waddr = a;
                    m_wdata = int'(req_data[m_owner*DW +: DW]);
                end
                if (req_last[m_owner]) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % NR;
                end
            end
        end
    end

    task automatic set_req(input int i, input bit v, input bit l, input int a, input int d);
        req_valid[i] = v;
        req_last[i]  = l;
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = DW'(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (write_addr !== '0 || write_data !== '0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: addr=%0d data=%0h owner=%0d want 0/0/0",
                     write_addr, write_data, owner);
        end
        checks++; if (oob_count !== 16'd0) begin
            errors++; $display("FAIL reset_oob: got %0d want 0", oob_count);
        end
        repeat (10) begin
            @(negedge clk);
            checks++; if (write_en !== 1'b0 || req_ready !== 3'b000 || locked !== 1'b0) begin
                errors++;
                $display("FAIL idle: wen=%0b ready=%b locked=%0b want 0/000/0",
                         write_en, req_ready, locked);
            end
        end
    endtask

    task automatic test_burst();
        do_reset();
        set_req(1, 1, 0, 10, 'h0A0);
        checks++; if (req_ready !== 3'b000) begin
            errors++; $display("FAIL burst_ready0: got %b want 000", req_ready);
        end
        @(negedge clk);
        checks++; if (req_ready !== 3'b010 || owner !== 2'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL burst_grant: ready=%b owner=%0d locked=%0b want 010/1/1",
                     req_ready, owner, locked);
        end
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            checks++; if (write_en !== 1'b1 || write_addr !== AW'(10 + b - 1) ||
                          write_data !== 12'h0A0) begin
                errors++;
                $display("FAIL burst_write%0d: wen=%0b addr=%0d data=%0h want 1/%0d/0a0",
                         b, write_en, write_addr, write_data, 10 + b - 1);
            end
            if (b < 4) begin
                checks++; if (locked !== 1'b1) begin
                    errors++; $display("FAIL burst_locked%0d: got %0b want 1", b, locked);
                end
                set_req(1, 1, b == 3, 10 + b, 'h0A0);
            end else begin
                checks++; if (locked !== 1'b0 || req_ready !== 3'b000) begin
                    errors++;
                    $display("FAIL burst_unlock: locked=%0b ready=%b want 0/000",
                             locked, req_ready);
                end
                set_req(1, 0, 0, 0, 0);
            end
        end
        @(negedge clk);
        checks++; if (write_en !== 1'b0) begin
            errors++; $display("FAIL burst_after: wen=%0b want 0", write_en);
        end
    endtask

    task automatic test_round_robin();
        int beat[NR];
        int burst[NR];
        int wa[8];
        int wt[8];
        int gr[8];
        int nw = 0;
        int ng = 0;
        bit prev_locked = 0;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            beat[i] = 0; burst[i] = 0;
            set_req(i, 1, 0, i * 100, 'h100 + i);
        end
        for (int cyc = 0; cyc < 40 && nw < 8; cyc++) begin
            @(negedge clk);
            if (locked && !prev_locked && ng < 8) begin gr[ng] = int'(owner); ng++; end
            prev_locked = locked;
            if (write_en && nw < 8) begin wa[nw] = int'(write_addr); wt[nw] = cyc; nw++; end
            for (int i = 0; i < NR; i++) begin
                if (hs_vec[i]) begin
                    beat[i]++;
                    if (beat[i] == 2) begin beat[i] = 0; burst[i]++; end
                    set_req(i, 1, beat[i] == 1, i * 100 + burst[i] * 10 + beat[i], 'h100 + i);
                end
            end
        end
        req_valid = '0;
        checks++; if (nw != 8 || ng < 4) begin
            errors++; $display("FAIL rr_count: writes=%0d grants=%0d want 8/>=4", nw, ng);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (gr[k] != k % 3) begin
                    errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, gr[k], k % 3);
                end
            end
            for (int j = 0; j < 8; j++) begin
                int k = j / 2;
                int exp_a = (k % 3) * 100 + (k / 3) * 10 + j % 2;
                checks++; if (wa[j] != exp_a || wt[j] != wt[0] + 3 * k + j % 2) begin
                    errors++;
                    $display("FAIL rr_write%0d: addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                             j, wa[j], wt[j], exp_a, wt[0] + 3 * k + j % 2);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_req(0, 1, 0, 200, 'h111);
        set_req(2, 1, 1, 300, 'h333);
        @(negedge clk);
        checks++; if (owner !== 2'd0 || req_ready !== 3'b001) begin
            errors++; $display("FAIL stall_grant: owner=%0d ready=%b want 0/001", owner, req_ready);
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            checks++; if (write_en !== 1'b1 || write_addr !== AW'(200 + b)) begin
                errors++;
                $display("FAIL stall_pre%0d: wen=%0b addr=%0d want 1/%0d", b, write_en,
                         write_addr, 200 + b);
            end
            set_req(0, b == 0, 0, 201, 'h111);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (write_en !== 1'b0 || owner !== 2'd0 || locked !== 1'b1 ||
                          req_ready !== 3'b001) begin
                errors++;
                $display("FAIL stall_gap%0d: wen=%0b owner=%0d locked=%0b ready=%b want 0/0/1/001",
                         c, write_en, owner, locked, req_ready);
            end
        end
        set_req(0, 1, 0, 202, 'h111);
        @(negedge clk);
        checks++; if (write_en !== 1'b1 || write_addr !== AW'(202)) begin
            errors++; $display("FAIL stall_resume: wen=%0b addr=%0d want 1/202", write_en, write_addr);
        end
        set_req(0, 1, 1, 203, 'h111);
        @(negedge clk);
        checks++; if (write_en !== 1'b1 || write_addr !== AW'(203) || locked !== 1'b0) begin
            errors++;
            $display("FAIL stall_last: wen=%0b addr=%0d locked=%0b want 1/203/0",
                     write_en, write_addr, locked);
        end
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (owner !== 2'd2 || req_ready !== 3'b100) begin
            errors++; $display("FAIL stall_next: owner=%0d ready=%b want 2/100", owner, req_ready);
        end
        @(negedge clk);
        checks++; if (write_en !== 1'b1 || write_addr !== AW'(300) || write_data !== 12'h333) begin
            errors++;
            $display("FAIL stall_r2: wen=%0b addr=%0d data=%0h want 1/300/333",
                     write_en, write_addr, write_data);
        end
        set_req(2, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(0, 1, 1, 5, 'h005);
        @(negedge clk);
        @(negedge clk);
        checks++; if (write_en !== 1'b1 || write_addr !== AW'(5)) begin
            errors++; $display("FAIL rmb_single: wen=%0b addr=%0d want 1/5", write_en, write_addr);
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 0, 400, 'h444);
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin
            errors++; $display("FAIL rmb_grant1: ready=%b want 010", req_ready);
        end
        for (int b = 1; b <= 2; b++) begin
            @(negedge clk);
            checks++; if (write_en !== 1'b1 || write_addr !== AW'(400 + b - 1)) begin
                errors++;
                $display("FAIL rmb_beat%0d: wen=%0b addr=%0d want 1/%0d", b, write_en,
                         write_addr, 400 + b - 1);
            end
            set_req(1, 1, 0, 400 + b, 'h444);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (write_en !== 1'b0 || locked !== 1'b0 || req_ready !== 3'b000) begin
            errors++;
            $display("FAIL rmb_reset: wen=%0b locked=%0b ready=%b want 0/0/000",
                     write_en, locked, req_ready);
        end
        rst = 1'b0;
        set_req(0, 1, 1, 7, 'h077);
        @(negedge clk);
        checks++; if (owner !== 2'd0 || req_ready !== 3'b001) begin
            errors++; $display("FAIL rmb_ptr0: owner=%0d ready=%b want 0/001", owner, req_ready);
        end
        @(negedge clk);
        checks++; if (write_en !== 1'b1 || write_addr !== AW'(7)) begin
            errors++; $display("FAIL rmb_r0write: wen=%0b addr=%0d want 1/7", write_en, write_addr);
        end
        set_req(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (owner !== 2'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL rmb_then1: owner=%0d locked=%0b want 1/1", owner, locked);
        end
    endtask

    task automatic test_bounds();
        do_reset();
        set_req(2, 1, 0, 19200, 'h111);
        @(negedge clk);
        checks++; if (req_ready !== 3'b100) begin
            errors++; $display("FAIL oob_grant: ready=%b want 100", req_ready);
        end
        @(negedge clk);
        checks++; if (write_en !== !BoundsEn) begin
            errors++; $display("FAIL oob_first: wen=%0b want %0b", write_en, !BoundsEn);
        end
        if (!BoundsEn) begin
            checks++; if (write_addr !== AW'(19200)) begin
                errors++; $display("FAIL oob_first_addr: got %0d want 19200", write_addr);
            end
        end
        set_req(2, 1, 1, 19199, 'h222);
        @(negedge clk);
        checks++; if (write_en !== 1'b1 || write_addr !== AW'(19199) || write_data !== 12'h222) begin
            errors++;
            $display("FAIL oob_second: wen=%0b addr=%0d data=%0h want 1/19199/222",
                     write_en, write_addr, write_data);
        end
        checks++; if (oob_count !== (BoundsEn ? 16'd1 : 16'd0) || locked !== 1'b0) begin
            errors++;
            $display("FAIL oob_count: got %0d locked=%0b want %0d/0", oob_count, locked,
                     BoundsEn ? 1 : 0);
        end
        set_req(2, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int rem[NR];
        int a;
        logic [NR-1:0] exp_ready;
        do_reset();
        for (int i = 0; i < NR; i++) rem[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_ready = m_busy ? NR'(1 << m_owner) : '0;
            checks++; if (req_ready !== exp_ready || locked !== m_busy ||
                          (m_busy && owner !== 2'(m_owner))) begin
                errors++;
                $display("FAIL rnd_ctrl@%0d: ready=%b locked=%0b owner=%0d want %b/%0b/%0d",
                         cyc, req_ready, locked, owner, exp_ready, m_busy, m_owner);
            end
            checks++; if (write_en !== m_wen ||
                          (m_wen && (write_addr !== AW'(m_waddr) || write_data !== DW'(m_wdata)))) begin
                errors++;
                $display("FAIL rnd_write@%0d: wen=%0b addr=%0d data=%0h want %0b/%0d/%0h",
                         cyc, write_en, write_addr, write_data, m_wen, m_waddr, m_wdata);
            end
            checks++; if (oob_count !== 16'(m_oob)) begin
                errors++; $display("FAIL rnd_oob@%0d: got %0d want %0d", cyc, oob_count, m_oob);
            end
            for (int i = 0; i < NR; i++) begin
                if (hs_vec[i]) begin
                    rem[i]--;
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                    a = ($urandom_range(0, 7) == 0) ? $urandom_range(19200, 32767)
                                                    : $urandom_range(0, 19199);
                    set_req(i, 1, rem[i] == 1, a, $urandom);
                end
            end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_round_robin();
        test_stall();
        test_reset_mid_burst();
        test_bounds();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
